// File: rtl/ipsxb_qsgmii_pcs_tx_ctrl_v1_0.sv
// QSGMII PCS TX per-port sequencer: forced idle until SERDES ready and settled, then
// switches each port only on K28.5 boundaries. Optional QSGMII_TX_K28_1_SUB_EN: port 0 uses K28.1.
// Latency 1 cycle in pass and idle modes; no backpressure, upstream is never stalled.
module ipsxb_qsgmii_pcs_tx_ctrl_v1_0 #(
  parameter int STARTUP_CYCLES = 64,
  parameter int ALIGN_TIMEOUT  = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_ready,
  input  logic [3:0] port_en,
  input  logic [7:0] p0_txd_in,
  input  logic [7:0] p1_txd_in,
  input  logic [7:0] p2_txd_in,
  input  logic [7:0] p3_txd_in,
  input  logic       p0_txk_in,
  input  logic       p1_txk_in,
  input  logic       p2_txk_in,
  input  logic       p3_txk_in,
  output logic [7:0] p0_txd_out,
  output logic [7:0] p1_txd_out,
  output logic [7:0] p2_txd_out,
  output logic [7:0] p3_txd_out,
  output logic       p0_txk_out,
  output logic       p1_txk_out,
  output logic       p2_txk_out,
  output logic       p3_txk_out,
  output logic [3:0] port_active,
  output logic [1:0] ctrl_state,
  output logic [3:0] align_err
);

  localparam int SW = (STARTUP_CYCLES > 2) ? $clog2(STARTUP_CYCLES) : 1;
  localparam int AW = $clog2(ALIGN_TIMEOUT + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(STARTUP_CYCLES - 1);
  localparam logic [AW-1:0] TIMEOUT     = AW'(ALIGN_TIMEOUT);
  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K28_1 = 8'h3C;
  localparam logic [7:0] D16_2 = 8'h50;
`ifdef QSGMII_TX_K28_1_SUB_EN
  localparam logic [7:0] P0_COMMA = K28_1;
`else
  localparam logic [7:0] P0_COMMA = K28_5;
`endif

  typedef enum logic [1:0] {
    ST_RESET    = 2'd0,
    ST_WAIT_RDY = 2'd1,
    ST_SETTLE   = 2'd2,
    ST_RUN      = 2'd3
  } state_t;

  state_t          state;
  logic [SW-1:0]   settle_cnt;
  logic [7:0]      din [4];
  logic [3:0]      kin;
  logic [7:0]      dq [4];
  logic [3:0]      kq;
  // phase[i] is the idle phase of the byte produced by the next register update
  logic [3:0]      phase;
  logic [AW-1:0]   tcnt [4];

  logic            run_ok;
  logic            run_drop;
  logic [3:0]      bnd;
  logic [3:0]      pend;
  logic [7:0]      nxt_d [4];
  logic [3:0]      nxt_k;
  logic [3:0]      nxt_phase;
  logic [3:0]      nxt_active;
  logic [AW-1:0]   nxt_cnt [4];
  logic [3:0]      nxt_err;

  assign din[0] = p0_txd_in;
  assign din[1] = p1_txd_in;
  assign din[2] = p2_txd_in;
  assign din[3] = p3_txd_in;
  assign kin    = {p3_txk_in, p2_txk_in, p1_txk_in, p0_txk_in};

  assign p0_txd_out = dq[0];
  assign p1_txd_out = dq[1];
  assign p2_txd_out = dq[2];
  assign p3_txd_out = dq[3];
  assign {p3_txk_out, p2_txk_out, p1_txk_out, p0_txk_out} = kq;
  assign ctrl_state = state;

  always_comb begin
    run_ok     = (state == ST_RUN) && tx_ready;
    run_drop   = (state == ST_RUN) && !tx_ready;
    bnd        = '0;
    pend       = '0;
    nxt_k      = '0;
    nxt_phase  = '0;
    nxt_active = '0;
    nxt_err    = align_err;
    for (int i = 0; i < 4; i++) begin
      bnd[i]       = (din[i] == K28_5) && kin[i];
      nxt_d[i]     = phase[i] ? D16_2 : K28_5;
      nxt_k[i]     = ~phase[i];
      nxt_phase[i] = ~phase[i];
      nxt_cnt[i]   = '0;
      if (run_drop) begin
        nxt_d[i]     = K28_5;
        nxt_k[i]     = 1'b1;
        nxt_phase[i] = 1'b1;
      end else if (run_ok && port_active[i]) begin
        nxt_d[i]      = din[i];
        nxt_k[i]      = kin[i];
        nxt_phase[i]  = phase[i];
        nxt_active[i] = 1'b1;
        if (!port_en[i]) begin
          if (bnd[i]) begin
            // leave on the upstream comma so the idle stream continues with D16.2
            nxt_d[i]      = K28_5;
            nxt_k[i]      = 1'b1;
            nxt_phase[i]  = 1'b1;
            nxt_active[i] = 1'b0;
          end else begin
            pend[i] = 1'b1;
          end
        end
      end else if (run_ok && port_en[i]) begin
        if (!phase[i] && bnd[i]) begin
          nxt_d[i]      = din[i];
          nxt_k[i]      = kin[i];
          nxt_phase[i]  = 1'b0;
          nxt_active[i] = 1'b1;
        end else begin
          pend[i] = 1'b1;
        end
      end
      if (pend[i]) begin
        if (tcnt[i] == TIMEOUT) begin
          nxt_cnt[i] = tcnt[i];
        end else begin
          nxt_cnt[i] = tcnt[i] + AW'(1);
          if (tcnt[i] + AW'(1) == TIMEOUT) nxt_err[i] = 1'b1;
        end
      end
    end
`ifdef QSGMII_TX_K28_1_SUB_EN
    if (nxt_d[0] == K28_5 && nxt_k[0]) nxt_d[0] = K28_1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_RESET;
      settle_cnt  <= '0;
      port_active <= '0;
      align_err   <= '0;
      phase       <= '0;
      kq          <= '1;
      for (int i = 0; i < 4; i++) begin
        dq[i]   <= (i == 0) ? P0_COMMA : K28_5;
        tcnt[i] <= '0;
      end
    end else begin
      case (state)
        ST_RESET:    state <= ST_WAIT_RDY;
        ST_WAIT_RDY: begin
          if (tx_ready) begin
            state      <= ST_SETTLE;
            settle_cnt <= '0;
          end
        end
        ST_SETTLE: begin
          if (!tx_ready) begin
            state <= ST_WAIT_RDY;
          end else if (settle_cnt == SETTLE_LAST) begin
            state <= ST_RUN;
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end
        default: begin
          if (!tx_ready) state <= ST_WAIT_RDY;
        end
      endcase
      port_active <= nxt_active;
      align_err   <= nxt_err;
      phase       <= nxt_phase;
      kq          <= nxt_k;
      for (int i = 0; i < 4; i++) begin
        dq[i]   <= nxt_d[i];
        tcnt[i] <= nxt_cnt[i];
      end
    end
  end

endmodule

// File: tb/tb_ipsxb_qsgmii_pcs_tx_ctrl_v1_0.sv
// Bench for ipsxb_qsgmii_pcs_tx_ctrl_v1_0: reset table, directed corner sequences, random run vs model.
module tb_ipsxb_qsgmii_pcs_tx_ctrl_v1_0;

  localparam int STARTUP = 64;
  localparam int TO      = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_ready;
  logic [3:0] port_en;
  logic [7:0] din [4];
  logic [3:0] kin;
  logic [7:0] o_d0, o_d1, o_d2, o_d3;
  logic       o_k0, o_k1, o_k2, o_k3;
  logic [7:0] dout [4];
  logic [3:0] kout;
  logic [3:0] port_active;
  logic [1:0] ctrl_state;
  logic [3:0] align_err;

  always #5 clk = ~clk;

  ipsxb_qsgmii_pcs_tx_ctrl_v1_0 #(.STARTUP_CYCLES(STARTUP), .ALIGN_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .tx_ready(tx_ready), .port_en(port_en),
    .p0_txd_in(din[0]), .p1_txd_in(din[1]), .p2_txd_in(din[2]), .p3_txd_in(din[3]),
    .p0_txk_in(kin[0]), .p1_txk_in(kin[1]), .p2_txk_in(kin[2]), .p3_txk_in(kin[3]),
    .p0_txd_out(o_d0), .p1_txd_out(o_d1), .p2_txd_out(o_d2), .p3_txd_out(o_d3),
    .p0_txk_out(o_k0), .p1_txk_out(o_k1), .p2_txk_out(o_k2), .p3_txk_out(o_k3),
    .port_active(port_active), .ctrl_state(ctrl_state), .align_err(align_err)
  );

  assign dout[0] = o_d0;
  assign dout[1] = o_d1;
  assign dout[2] = o_d2;
  assign dout[3] = o_d3;
  assign kout    = {o_k3, o_k2, o_k1, o_k0};

  int checks = 0;
  int errors = 0;

  // Reference model: stage 0..3, per-port "next idle byte is a comma" flag and wait counters.
  int       m_stage;
  int       m_settle;
  bit [7:0] m_d [4];
  bit [3:0] m_k;
  bit [3:0] m_act;
  bit [3:0] m_comma;
  bit [3:0] m_err;
  int       m_wait [4];

  function automatic logic [7:0] line_byte(int port, logic [7:0] d, logic k);
`ifdef QSGMII_TX_K28_1_SUB_EN
    if (port == 0 && d == 8'hBC && k) return 8'h3C;
`endif
    return d;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_step();
    bit run, drop, pend, bnd;
    if (rst) begin
      m_stage = 0; m_settle = 0; m_act = '0; m_comma = '1; m_err = '0; m_k = '1;
      for (int i = 0; i < 4; i++) begin m_d[i] = 8'hBC; m_wait[i] = 0; end
      return;
    end
    run  = (m_stage == 3) && tx_ready;
    drop = (m_stage == 3) && !tx_ready;
    for (int i = 0; i < 4; i++) begin
      bnd  = (din[i] == 8'hBC) && kin[i];
      pend = 0;
      if (drop) begin
        m_d[i] = 8'hBC; m_k[i] = 1; m_comma[i] = 0; m_act[i] = 0;
      end else if (run && m_act[i] && port_en[i]) begin
        m_d[i] = din[i]; m_k[i] = kin[i];
      end else if (run && m_act[i]) begin
        if (bnd) begin
          m_d[i] = 8'hBC; m_k[i] = 1; m_comma[i] = 0; m_act[i] = 0;
        end else begin
          m_d[i] = din[i]; m_k[i] = kin[i]; pend = 1;
        end
      end else if (run && port_en[i] && m_comma[i] && bnd) begin
        m_d[i] = din[i]; m_k[i] = kin[i]; m_act[i] = 1;
      end else begin
        m_d[i] = m_comma[i] ? 8'hBC : 8'h50;
        m_k[i] = m_comma[i];
        m_comma[i] = !m_comma[i];
        pend = run && port_en[i];
      end
      if (pend) begin
        if (m_wait[i] < TO) m_wait[i]++;
        if (m_wait[i] == TO) m_err[i] = 1;
      end else begin
        m_wait[i] = 0;
      end
    end
    case (m_stage)
      0: m_stage = 1;
      1: if (tx_ready) begin m_stage = 2; m_settle = 0; end
      2: begin
        if (!tx_ready) m_stage = 1;
        else begin
          m_settle++;
          if (m_settle == STARTUP) m_stage = 3;
        end
      end
      default: if (!tx_ready) m_stage = 1;
    endcase
  endtask

  task automatic check_model();
    for (int i = 0; i < 4; i++)
      chk($sformatf("model_port%0d_dk", i), {dout[i], kout[i]}, {line_byte(i, m_d[i], m_k[i]), m_k[i]});
    chk("model_port_active", port_active, m_act);
    chk("model_ctrl_state", ctrl_state, m_stage);
    chk("model_align_err", align_err, m_err);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  typedef struct {
    logic       rst;
    logic       txr;
    logic [7:0] d3;
    logic       k3;
    logic [1:0] st;
  } vec_t;

  initial begin
    vec_t       tbl [9];
    logic [7:0] sent [4];
    int         n;

    tbl[0] = '{1, 0, 8'hBC, 1, 0};
    tbl[1] = '{1, 0, 8'hBC, 1, 0};
    tbl[2] = '{1, 0, 8'hBC, 1, 0};
    tbl[3] = '{0, 0, 8'hBC, 1, 1};
    tbl[4] = '{0, 0, 8'h50, 0, 1};
    tbl[5] = '{0, 0, 8'hBC, 1, 1};
    tbl[6] = '{0, 0, 8'h50, 0, 1};
    tbl[7] = '{0, 1, 8'hBC, 1, 2};
    tbl[8] = '{0, 0, 8'h50, 0, 1};

    rst = 1; tx_ready = 0; port_en = 4'hF; kin = '1;
    for (int i = 0; i < 4; i++) din[i] = 8'hBC;

    for (int v = 0; v < 9; v++) begin
      rst = tbl[v].rst; tx_ready = tbl[v].txr;
      cycle();
      chk($sformatf("tbl%0d_p3", v), {dout[3], kout[3]}, {tbl[v].d3, tbl[v].k3});
      chk($sformatf("tbl%0d_state", v), ctrl_state, tbl[v].st);
      chk($sformatf("tbl%0d_active", v), port_active, 4'h0);
    end

    // bring-up with aligned commas on all ports
    tx_ready = 1;
    n = 0;
    while (ctrl_state != 2'd3 && n < 100) begin cycle(); n++; end
    chk("settle_cycles", n, STARTUP + 1);
    n = 0;
    while (port_active != 4'hF && n < 4) begin cycle(); n++; end
    chk("enable_all", port_active, 4'hF);
    chk("enable_within_2", n <= 2, 1);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) begin
        sent[i] = 8'($urandom_range(0, 187)); din[i] = sent[i]; kin[i] = 0;
      end
      cycle();
      for (int i = 0; i < 4; i++) chk($sformatf("pass%0d_p%0d", r, i), dout[i], sent[i]);
    end

    // port 2 drops its enable mid-frame
    for (int f = 0; f < 20; f++) begin
      for (int i = 0; i < 4; i++) begin din[i] = 8'($urandom_range(0, 187)); kin[i] = 0; end
      sent[2] = din[2];
      port_en[2] = (f < 10);
      cycle();
      if (f == 19) begin
        chk("frame_fwd_p2", dout[2], sent[2]);
        chk("frame_active_p2", port_active[2], 1);
      end
    end
    din[2] = 8'hBC; kin[2] = 1;
    cycle();
    chk("disable_comma_p2", {dout[2], kout[2]}, {8'hBC, 1'b1});
    chk("disable_active_p2", port_active[2], 0);
    din[2] = 8'h11; kin[2] = 0;
    cycle();
    chk("disable_idle1_p2", {dout[2], kout[2]}, {8'h50, 1'b0});
    cycle();
    chk("disable_idle2_p2", {dout[2], kout[2]}, {8'hBC, 1'b1});

    // port 1 enable that never finds a boundary
    port_en[1] = 0; din[1] = 8'hBC; kin[1] = 1;
    cycle();
    chk("p1_off", port_active[1], 0);
    port_en[1] = 1; kin[1] = 0;
    for (int c = 0; c < TO; c++) begin
      din[1] = 8'($urandom_range(0, 187));
      cycle();
      if (c == TO - 2) chk("p1_err_before_timeout", align_err[1], 0);
    end
    chk("p1_err_at_timeout", align_err[1], 1);
    chk("p1_still_idle", port_active[1], 0);
    port_en[1] = 0;
    for (int c = 0; c < 5; c++) cycle();
    chk("p1_err_sticky", align_err[1], 1);

    // tx_ready loss with every port active
    port_en = 4'hF; kin = '1;
    for (int i = 0; i < 4; i++) din[i] = 8'hBC;
    n = 0;
    while (port_active != 4'hF && n < 4) begin cycle(); n++; end
    chk("reenable_all", port_active, 4'hF);
    tx_ready = 0; kin = '0;
    for (int i = 0; i < 4; i++) din[i] = 8'($urandom_range(0, 187));
    cycle();
    chk("drop_state", ctrl_state, 2'd1);
    chk("drop_active", port_active, 4'h0);
    for (int i = 0; i < 4; i++) chk($sformatf("drop_comma_p%0d", i), {dout[i], kout[i]}, {line_byte(i, 8'hBC, 1'b1), 1'b1});
    cycle();
    for (int i = 0; i < 4; i++) chk($sformatf("drop_d16_p%0d", i), {dout[i], kout[i]}, {8'h50, 1'b0});

    // random traffic against the model
    tx_ready = 1;
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 149) == 0) tx_ready = !tx_ready;
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 39) == 0) port_en[i] = !port_en[i];
        if ($urandom_range(0, 9) < 3) begin
          din[i] = 8'hBC; kin[i] = 1;
        end else begin
          din[i] = 8'($urandom); kin[i] = ($urandom_range(0, 7) == 0);
        end
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
